// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-PC predictor: 2-bit direction counter
// encoding plus saturating update functions.
package pc_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WEAK_NT;
  localparam ctr_t CTR_ALLOC = WEAK_T;

  function automatic ctr_t sat_inc(ctr_t c);
    case (c)
      STRONG_NT: return WEAK_NT;
      WEAK_NT:   return WEAK_T;
      default:   return STRONG_T;
    endcase
  endfunction

  function automatic ctr_t sat_dec(ctr_t c);
    case (c)
      STRONG_T: return WEAK_T;
      WEAK_T:   return WEAK_NT;
      default:  return STRONG_NT;
    endcase
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// synchronous allocate/train from the EX resolution port.
module btb_table
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int INST_BYTES  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int OFF   = $clog2(INST_BYTES);
  localparam int TAG_W = XLEN - OFF - IDX_W;

  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        target [BTB_ENTRIES];
  ctr_t                   ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;

  assign l_idx = lookup_pc[OFF +: IDX_W];
  assign l_tag = lookup_pc[OFF+IDX_W +: TAG_W];
  assign u_idx = upd_pc[OFF +: IDX_W];
  assign u_tag = upd_pc[OFF+IDX_W +: TAG_W];

  // Byte-offset bits never reach the table.
  logic unused_off;
  assign unused_off = ^{lookup_pc[OFF-1:0], upd_pc[OFF-1:0]};

  assign l_hit         = valid[l_idx] && (tag[l_idx] == l_tag);
  assign u_hit         = valid[u_idx] && (tag[u_idx] == u_tag);
  assign lookup_taken  = l_hit && ctr[l_idx][1];
  assign lookup_target = l_hit ? target[l_idx] : '0;

  // No bypass: a same-cycle lookup reads the pre-edge contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_RESET;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctr[u_idx]    <= sat_inc(ctr[u_idx]);
          target[u_idx] <= upd_target;
        end else begin
          ctr[u_idx]    <= sat_dec(ctr[u_idx]);
        end
      end else if (upd_taken) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= upd_target;
        ctr[u_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// IF-stage fetch PC register with BTB-driven next-PC selection and EX redirect.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              BTB_ENTRIES  = 16,
  parameter int              INST_BYTES   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  output logic [XLEN-1:0] pc_current,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_redirect_pc
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0] pc_q, pc_next;

  btb_table #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .INST_BYTES  (INST_BYTES)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (pc_q),
    .lookup_taken  (pred_taken),
    .lookup_target (pred_target),
    .upd_valid     (ex_valid),
    .upd_pc        (ex_pc),
    .upd_taken     (ex_taken),
    .upd_target    (ex_target)
  );

  // A flush from EX beats a hazard stall.
  always_comb begin
    pc_next = pc_q + STEP;
    if (ex_redirect)     pc_next = ex_redirect_pc;
    else if (!pc_write)  pc_next = pc_q;
    else if (pred_taken) pc_next = pred_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_next;
  end

  assign pc_current = pc_q;

endmodule
